// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage_if
//  Purpose  : Op-issue, ALU drive, result and external-write signals of the
//             ALU issue stage, bundled with master (environment) and slave
//             (stage) views.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 3
) ();
    // Op issue handshake
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [AW-1:0]     in_rd;
    logic [AW-1:0]     in_rs1;
    logic [AW-1:0]     in_rs2;
    logic              in_imm_en;
    logic [DATA_W-1:0] in_imm;
    // ALU drive / capture
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    // Result handshake
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_rd;
    logic              res_zero;
    // External register write
    logic              ext_we;
    logic [AW-1:0]     ext_waddr;
    logic [DATA_W-1:0] ext_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        output alu_result, res_ready, ext_we, ext_waddr, ext_wdata,
        input  in_ready, alu_a, alu_b, alu_ctrl,
        input  res_valid, res_data, res_rd, res_zero
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
        input  alu_result, res_ready, ext_we, ext_waddr, ext_wdata,
        output in_ready, alu_a, alu_b, alu_ctrl,
        output res_valid, res_data, res_rd, res_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Execute-stage controller in front of a combinational ALU.
//             Accepts ops, reads operands from an internal register file,
//             drives registered operands/control into the ALU, writes the
//             ALU result back and offers it downstream.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 8,
    parameter int ZERO_R0 = 1
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    alu_issue_stage_if.slave   bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_ctrl_q, alu_ctrl_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [AW-1:0]     res_rd_q, res_rd_d;
    logic              res_zero_q, res_zero_d;

    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    // Handshake: a new op may enter when idle, or when the held result leaves this cycle
    assign w_in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.res_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Operand read; r0 is hardwired to zero when enabled. No bypass of same-cycle external writes.
    assign w_rs1_val = ((ZERO_R0 != 0) && (bus.in_rs1 == '0)) ? '0 : regs_q[bus.in_rs1];
    assign w_rs2_val = ((ZERO_R0 != 0) && (bus.in_rs2 == '0)) ? '0 : regs_q[bus.in_rs2];

    // Next-state, operand latch, result capture and register-file update
    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rd_d       = rd_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        res_zero_d = res_zero_q;

        // External write first so a same-address EXEC writeback overrides it
        if (bus.ext_we && !((ZERO_R0 != 0) && (bus.ext_waddr == '0))) begin
            regs_d[bus.ext_waddr] = bus.ext_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d = bus.alu_result;
                res_rd_d   = rd_q;
                res_zero_d = (bus.alu_result == '0);
                if (!((ZERO_R0 != 0) && (rd_q == '0))) begin
                    regs_d[rd_q] = bus.alu_result;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = w_accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operands are only reloaded on accept, so they stay stable through EXEC and DONE
        if (w_accept) begin
            alu_a_d    = w_rs1_val;
            alu_b_d    = bus.in_imm_en ? bus.in_imm : w_rs2_val;
            alu_ctrl_d = bus.in_op;
            rd_d       = bus.in_rd;
        end
    end

    // State and datapath registers; reset discards any op in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            regs_q     <= '{default: '0};
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            rd_q       <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rd_q       <= rd_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_zero  = res_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage with a behavioural ALU.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;
    localparam int DATA_W = 8;
    localparam int AW     = 3;
    localparam logic [1:0] OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11;

    logic clk = 1'b0;
    logic reset_n;

    alu_issue_stage_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    alu_issue_stage #(.DATA_W(DATA_W), .NREGS(8), .ZERO_R0(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU sitting downstream of the stage
    always_comb begin
        case (bus.alu_ctrl)
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
            default: bus.alu_result = bus.alu_a - bus.alu_b;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        imm_en;
        logic [7:0]  imm;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] rd;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] data, input logic [2:0] rd);
        exp_t e;
        e.data = data;
        e.rd   = rd;
        e.zero = (data == 8'h00);
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s_scoreboard: got result with empty queue expected none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res_data"}, bus.res_data, e.data);
            chk({tag, "_res_rd"},   bus.res_rd,   e.rd);
            chk({tag, "_res_zero"}, bus.res_zero, e.zero);
        end
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [7:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm_en = imm_en;
        bus.in_imm    = imm;
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [7:0] data);
        bus.ext_we    = 1'b1;
        bus.ext_waddr = addr;
        bus.ext_wdata = data;
        tick();
        bus.ext_we    = 1'b0;
    endtask

    // One op from IDLE with res_ready high; xmode 1 = ext write in accept cycle, 2 = in EXEC cycle
    task automatic issue_op(input string tag, input logic [1:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_en,
                            input logic [7:0] imm, input logic [7:0] exp,
                            input int xmode, input logic [2:0] xaddr, input logic [7:0] xdata);
        bus.res_ready = 1'b1;
        drive_op(op, rd, rs1, rs2, imm_en, imm);
        if (xmode == 1) begin
            bus.ext_we = 1'b1; bus.ext_waddr = xaddr; bus.ext_wdata = xdata;
        end
        chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
        push_exp(exp, rd);
        tick();
        bus.in_valid = 1'b0;
        bus.ext_we   = 1'b0;
        if (xmode == 2) begin
            bus.ext_we = 1'b1; bus.ext_waddr = xaddr; bus.ext_wdata = xdata;
        end
        chk({tag, "_exec_not_valid"}, bus.res_valid, 0);
        tick();
        bus.ext_we = 1'b0;
        chk({tag, "_done_valid"}, bus.res_valid, 1);
        pop_compare(tag);
        tick();
    endtask

    // Observe a register through the datapath: OR rX, rX, #0 writes back the same value
    task automatic readreg(input logic [2:0] idx, input logic [7:0] exp);
        issue_op("readreg", OP_OR, idx, idx, 3'd0, 1'b1, 8'h00, exp, 0, 3'd0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'hFF};
        vecs[1] = '{OP_AND, 3'd5, 3'd3, 3'd0, 1'b1, 8'h0F, 8'h0F};
        vecs[2] = '{OP_OR,  3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 8'hFF};
        vecs[3] = '{OP_SUB, 3'd4, 3'd1, 3'd0, 1'b1, 8'h10, 8'hFF};
        vecs[4] = '{OP_SUB, 3'd7, 3'd3, 3'd3, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{OP_OR,  3'd0, 3'd1, 3'd2, 1'b0, 8'h00, 8'hFF};
        vecs[6] = '{OP_OR,  3'd6, 3'd0, 3'd0, 1'b1, 8'h00, 8'h00};
        vecs[7] = '{OP_ADD, 3'd6, 3'd3, 3'd0, 1'b1, 8'h01, 8'h00};
        vecs[8] = '{OP_OR,  3'd2, 3'd4, 3'd0, 1'b1, 8'h00, 8'hFF};

        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_imm_en = 1'b0; bus.in_imm = '0; bus.res_ready = 1'b1;
        bus.ext_we = 1'b0; bus.ext_waddr = '0; bus.ext_wdata = '0;
        tick(); tick();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_alu_a",     bus.alu_a, 0);
        chk("rst_alu_b",     bus.alu_b, 0);
        chk("rst_alu_ctrl",  bus.alu_ctrl, 0);
        chk("rst_res_data",  bus.res_data, 0);
        chk("rst_in_ready",  bus.in_ready, 1);
        reset_n = 1'b1;
        tick();

        // Table-driven op sequence
        ext_write(3'd1, 8'h0F);
        ext_write(3'd2, 8'hF0);
        for (int i = 0; i < 9; i++) begin
            issue_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                     vecs[i].imm_en, vecs[i].imm, vecs[i].exp, 0, 3'd0, 8'h00);
        end
        readreg(3'd0, 8'h00);
        readreg(3'd3, 8'hFF);

        // Wrap cases
        ext_write(3'd1, 8'h05);
        issue_op("sub_wrap", OP_SUB, 3'd4, 3'd1, 3'd0, 1'b1, 8'h06, 8'hFF, 0, 3'd0, 8'h00);
        ext_write(3'd1, 8'h80);
        ext_write(3'd2, 8'h80);
        issue_op("add_wrap", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h00, 0, 3'd0, 8'h00);

        // Backpressure followed by back-to-back dependent op
        ext_write(3'd1, 8'h0F);
        ext_write(3'd2, 8'hF0);
        bus.res_ready = 1'b0;
        drive_op(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        push_exp(8'hFF, 3'd3);
        tick();
        drive_op(OP_AND, 3'd5, 3'd3, 3'd0, 1'b1, 8'h0F);
        chk("b2b_exec_in_ready", bus.in_ready, 0);
        chk("b2b_exec_alu_a", bus.alu_a, 8'h0F);
        chk("b2b_exec_alu_b", bus.alu_b, 8'hF0);
        chk("b2b_exec_ctrl",  bus.alu_ctrl, OP_ADD);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_in_ready",  bus.in_ready, 0);
            chk("bp_res_data",  bus.res_data, 8'hFF);
            chk("bp_res_rd",    bus.res_rd, 3);
            chk("bp_alu_a",     bus.alu_a, 8'h0F);
            chk("bp_alu_b",     bus.alu_b, 8'hF0);
            tick();
        end
        bus.res_ready = 1'b1;
        #1;
        chk("b2b_done_in_ready", bus.in_ready, 1);
        pop_compare("b2b_first");
        push_exp(8'h0F, 3'd5);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_second_exec", bus.res_valid, 0);
        chk("b2b_second_alu_a", bus.alu_a, 8'hFF);
        chk("b2b_second_alu_b", bus.alu_b, 8'h0F);
        chk("b2b_second_ctrl",  bus.alu_ctrl, OP_AND);
        tick();
        chk("b2b_second_valid", bus.res_valid, 1);
        pop_compare("b2b_second");
        tick();
        chk("b2b_idle_valid", bus.res_valid, 0);
        chk("b2b_idle_ready", bus.in_ready, 1);

        // Register-file write collisions
        issue_op("coll_same", OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 8'h01, 8'h10, 2, 3'd3, 8'hAA);
        readreg(3'd3, 8'h10);
        issue_op("coll_diff", OP_ADD, 3'd6, 3'd1, 3'd0, 1'b1, 8'h02, 8'h11, 2, 3'd7, 8'h5A);
        readreg(3'd7, 8'h5A);
        readreg(3'd6, 8'h11);
        issue_op("acc_ext", OP_OR, 3'd5, 3'd1, 3'd0, 1'b1, 8'h00, 8'h0F, 1, 3'd1, 8'h33);
        readreg(3'd1, 8'h33);
        ext_write(3'd0, 8'h77);
        readreg(3'd0, 8'h00);

        // Reset while an op is in EXEC
        bus.res_ready = 1'b1;
        drive_op(OP_ADD, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01);
        tick();
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_alu_a",     bus.alu_a, 0);
        chk("mid_rst_alu_b",     bus.alu_b, 0);
        chk("mid_rst_alu_ctrl",  bus.alu_ctrl, 0);
        tick();
        reset_n = 1'b1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        for (int r = 0; r < 8; r++) begin
            readreg(r[2:0], 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
